// File: rtl/estufa_climate_ctrl.sv
// Greenhouse heater/cooler scheduler: min run time, dead time between actuators, debounced sensor-fault lockout.
// Optional feature macro ESTUFA_AUTO_RECOVER_EN: FAULT also exits after FAULT_CNT consecutive good samples.
module estufa_climate_ctrl #(
  parameter int MIN_ON    = 4,
  parameter int DEAD      = 2,
  parameter int FAULT_CNT = 3,
  parameter int CW        = 8
) (
  input  logic       clk_2,
  input  logic       rst_n,
  input  logic       t1,
  input  logic       t2,
  input  logic       enable,
  input  logic       fault_clr,
  output logic       heater,
  output logic       cooler,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAT  = 3'd1,
    ST_COOL  = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [CW-1:0] MIN_ON_M1 = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] DEAD_M1   = CW'(DEAD - 1);
  localparam logic [CW-1:0] FLT_M1    = CW'(FAULT_CNT - 1);
  localparam logic [CW-1:0] FLT_MAX   = CW'(FAULT_CNT);
  localparam logic [CW-1:0] RUN_MAX   = '1;
  localparam logic [CW-1:0] ONE       = CW'(1);

  state_e        state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic [CW-1:0] bad_cnt_q, bad_cnt_d;
  logic          heater_q, cooler_q, fault_q;

  logic cold, hot, bad;
  logic fault_hit;
  logic clr_exit;

  assign cold      = ~s1_q & ~s2_q;
  assign hot       =  s1_q &  s2_q;
  assign bad       = ~s1_q &  s2_q;
  assign fault_hit = bad && (bad_cnt_q == FLT_M1);

`ifdef ESTUFA_AUTO_RECOVER_EN
  logic [CW-1:0] good_cnt_q, good_cnt_d;
  logic          auto_exit;
  assign auto_exit = ~bad && (good_cnt_q == FLT_M1);
`endif

  always_comb begin
    state_d  = state_q;
    clr_exit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && cold)     state_d = ST_HEAT;
        else if (enable && hot) state_d = ST_COOL;
      end
      ST_HEAT: begin
        if (!enable)                                state_d = ST_DEAD;
        else if ((run_cnt_q >= MIN_ON_M1) && !cold) state_d = ST_DEAD;
      end
      ST_COOL: begin
        if (!enable)                               state_d = ST_DEAD;
        else if ((run_cnt_q >= MIN_ON_M1) && !hot) state_d = ST_DEAD;
      end
      ST_DEAD: begin
        if (run_cnt_q == DEAD_M1) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d  = ST_DEAD;
          clr_exit = 1'b1;
        end
`ifdef ESTUFA_AUTO_RECOVER_EN
        else if (auto_exit) begin
          state_d = ST_DEAD;
        end
`endif
      end
      default: state_d = ST_FAULT;
    endcase
    // A fault hit overrides every other decision, including a same-cycle clear.
    if (fault_hit) begin
      state_d  = ST_FAULT;
      clr_exit = 1'b0;
    end
  end

  always_comb begin
    if (state_d != state_q)     run_cnt_d = '0;
    else if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + ONE;
    else                        run_cnt_d = run_cnt_q;

    if (clr_exit || !bad)          bad_cnt_d = '0;
    else if (bad_cnt_q != FLT_MAX) bad_cnt_d = bad_cnt_q + ONE;
    else                           bad_cnt_d = bad_cnt_q;
  end

`ifdef ESTUFA_AUTO_RECOVER_EN
  // Good-sample run only accumulates while parked in FAULT.
  always_comb begin
    if ((state_q != ST_FAULT) || bad || (state_d != ST_FAULT)) good_cnt_d = '0;
    else if (good_cnt_q != FLT_MAX)                             good_cnt_d = good_cnt_q + ONE;
    else                                                        good_cnt_d = good_cnt_q;
  end

  always_ff @(posedge clk_2) begin
    if (!rst_n) good_cnt_q <= '0;
    else        good_cnt_q <= good_cnt_d;
  end
`endif

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      run_cnt_q <= '0;
      bad_cnt_q <= '0;
      heater_q  <= 1'b0;
      cooler_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= t1;
      s2_q      <= t2;
      run_cnt_q <= run_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      heater_q  <= (state_d == ST_HEAT);
      cooler_q  <= (state_d == ST_COOL);
      fault_q   <= (state_d == ST_FAULT);
    end
  end

  assign heater = heater_q;
  assign cooler = cooler_q;
  assign fault  = fault_q;
  assign state  = state_q;

endmodule

// File: tb/tb_estufa_climate_ctrl.sv
// Directed bench for estufa_climate_ctrl with MIN_ON=4, DEAD=2, FAULT_CNT=3.
module tb_estufa_climate_ctrl;

  logic       clk_2 = 1'b0;
  logic       rst_n;
  logic       t1, t2, enable, fault_clr;
  logic       heater, cooler, fault;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  estufa_climate_ctrl #(
    .MIN_ON(4), .DEAD(2), .FAULT_CNT(3), .CW(8)
  ) dut (
    .clk_2(clk_2), .rst_n(rst_n), .t1(t1), .t2(t2),
    .enable(enable), .fault_clr(fault_clr),
    .heater(heater), .cooler(cooler), .fault(fault), .state(state)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] st, input logic h, input logic c, input logic f);
    logic [5:0] obs;
    logic [5:0] expv;
    obs  = {state, fault, cooler, heater};
    expv = {st, f, c, h};
    checks++;
    $display("%s: state=%0d heater=%0b cooler=%0b fault=%0b", tag, state, heater, cooler, fault);
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed {st,f,c,h}=%b expected %b", tag, obs, expv);
    end
  endtask

  // Heater and cooler must never be driven together.
  always @(negedge clk_2) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(heater === 1'b1 && cooler === 1'b1)) else begin
        errors++;
        $error("FAIL overlap: heater=%b cooler=%b expected not both 1", heater, cooler);
      end
    end
  end

  initial begin
    rst_n = 1'b0; t1 = 1'b0; t2 = 1'b0; enable = 1'b0; fault_clr = 1'b0;
    tick(); tick();
    check("reset", 3'd0, 0, 0, 0);

    // Quiet start: ok sensors, disabled.
    rst_n = 1'b1; t1 = 1'b1; t2 = 1'b0;
    tick(); tick();
    check("idle_quiet", 3'd0, 0, 0, 0);

    // Heat cycle: cold -> heater two edges later.
    enable = 1'b1; t1 = 1'b0; t2 = 1'b0;
    tick(); check("heat_lat1", 3'd0, 0, 0, 0);
    tick(); check("heat_on", 3'd1, 1, 0, 0);
    t1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("heat_hold", 3'd1, 1, 0, 0);
    end
    tick(); check("heat_dead1", 3'd3, 0, 0, 0);
    tick(); check("heat_dead2", 3'd3, 0, 0, 0);
    tick(); check("heat_idle", 3'd0, 0, 0, 0);

    // Heat followed directly by hot: cooler only after DEAD and IDLE.
    t1 = 1'b0; t2 = 1'b0;
    tick(); check("h2c_lat", 3'd0, 0, 0, 0);
    tick(); check("h2c_heat", 3'd1, 1, 0, 0);
    t1 = 1'b1; t2 = 1'b1;
    repeat (3) tick();
    check("h2c_heat_end", 3'd1, 1, 0, 0);
    tick(); check("h2c_dead1", 3'd3, 0, 0, 0);
    tick(); check("h2c_dead2", 3'd3, 0, 0, 0);
    tick(); check("h2c_idle", 3'd0, 0, 0, 0);
    tick(); check("h2c_cool", 3'd2, 0, 1, 0);
    tick(); check("cool_hold", 3'd2, 0, 1, 0);

    // Reset for one edge mid-COOL.
    rst_n = 1'b0;
    tick(); check("rst_mid_cool", 3'd0, 0, 0, 0);
    rst_n = 1'b1; enable = 1'b0; t1 = 1'b1; t2 = 1'b0;
    tick(); check("post_rst_idle", 3'd0, 0, 0, 0);

    // Enable drop on second HEAT cycle overrides MIN_ON.
    enable = 1'b1; t1 = 1'b0; t2 = 1'b0;
    tick(); tick();
    check("en_heat", 3'd1, 1, 0, 0);
    tick(); check("en_heat2", 3'd1, 1, 0, 0);
    enable = 1'b0;
    tick(); check("en_drop_dead", 3'd3, 0, 0, 0);
    tick(); check("en_drop_dead2", 3'd3, 0, 0, 0);
    tick(); check("en_drop_idle", 3'd0, 0, 0, 0);

    // Fault: bad held -> fault on 4th edge.
    t1 = 1'b0; t2 = 1'b1;
    repeat (3) tick();
    check("fault_pre", 3'd0, 0, 0, 0);
    tick(); check("fault_on", 3'd4, 0, 0, 1);
    enable = 1'b1; t1 = 1'b1; t2 = 1'b0;
    tick(); check("fault_hold", 3'd4, 0, 0, 1);
    fault_clr = 1'b1;
    tick(); check("fault_clr_dead", 3'd3, 0, 0, 0);
    fault_clr = 1'b0; enable = 1'b0;
    tick(); check("fault_clr_dead2", 3'd3, 0, 0, 0);
    tick(); check("fault_clr_idle", 3'd0, 0, 0, 0);

    // Two-sample bad glitch must not fault.
    t1 = 1'b0; t2 = 1'b1;
    tick(); tick();
    t1 = 1'b1; t2 = 1'b0;
    tick(); check("glitch1", 3'd0, 0, 0, 0);
    tick(); check("glitch2", 3'd0, 0, 0, 0);
    tick(); check("glitch3", 3'd0, 0, 0, 0);

    // Collision: fault_clr on the cycle of a fresh fault hit stays in FAULT.
    t1 = 1'b0; t2 = 1'b1;
    repeat (4) tick();
    check("coll_fault", 3'd4, 0, 0, 1);
    t1 = 1'b1; t2 = 1'b0;
    tick();
    t1 = 1'b0; t2 = 1'b1;
    tick(); tick(); tick();
    check("coll_pre", 3'd4, 0, 0, 1);
    fault_clr = 1'b1;
    tick(); check("coll_hit_wins", 3'd4, 0, 0, 1);
    fault_clr = 1'b0;
    tick(); check("coll_stay", 3'd4, 0, 0, 1);

    // Good samples while in FAULT.
    t1 = 1'b1; t2 = 1'b0;
    repeat (3) tick();
    check("good_pre", 3'd4, 0, 0, 1);
    tick();
`ifdef ESTUFA_AUTO_RECOVER_EN
    check("auto_recover", 3'd3, 0, 0, 0);
`else
    check("no_auto_recover", 3'd4, 0, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
